mem_port_arbiter: RTL

- Shares one single-port, synchronous-read memory between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Sits between the core and the unified memory for the upcoming multicycle/pipelined core.
- Fixed priority to D, with anti-starvation for IF.
- Tracks the single outstanding read and routes its response back to the owning port.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter_starve_counter.sv | 24 ++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and funct3 access codes for the IF/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    // funct3 load/store width codes, shared with decode/control
    localparam logic [2:0] ACC_BYTE   = 3'b000;
    localparam logic [2:0] ACC_HALF   = 3'b001;
    localparam logic [2:0] ACC_WORD   = 3'b010;
    localparam logic [2:0] ACC_BYTE_U = 3'b100;
    localparam logic [2:0] ACC_HALF_U = 3'b101;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and memory port signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;

    logic          d_req_i;
    logic          d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic [2:0]    d_ctrl_i;
    logic          d_gnt_o;
    logic          d_rvalid_o;
    logic [DW-1:0] d_rdata_o;

    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [2:0]    mem_ctrl_o;
    logic [DW-1:0] mem_rdata_i;

    logic          busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_ctrl_i,
        input  mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ctrl_o,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_ctrl_i,
        output mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ctrl_o,
        input  busy_o
    );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating 4-bit count of consecutive denied fetch cycles.
module starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);
    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_at_limit = (r_cnt == LIMIT[3:0]);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: D has priority, IF wins once starved; tracks one outstanding read.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          AW           = 32,
    parameter int          DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    owner_t        r_owner;
    owner_t        w_owner_nxt;
    logic          w_at_limit;
    logic          w_gnt_if;
    logic          w_gnt_d;
    logic          w_mem_req;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic [2:0]    w_mem_ctrl;
    logic          w_if_rvalid;
    logic [DW-1:0] w_if_rdata;
    logic          w_d_rvalid;
    logic [DW-1:0] w_d_rdata;
    logic          w_starve_inc;
    logic          w_starve_clr;

    assign w_starve_inc = bus.if_req_i && !w_gnt_if;
    assign w_starve_clr = !bus.if_req_i || w_gnt_if;

    starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_starve_inc),
        .i_clr     (w_starve_clr),
        .o_at_limit(w_at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_gnt_d     = 1'b0;
        w_gnt_if    = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_ctrl  = '0;
        w_owner_nxt = OWN_NONE;
        w_if_rvalid = 1'b0;
        w_if_rdata  = '0;
        w_d_rvalid  = 1'b0;
        w_d_rdata   = '0;

        // Grants are held off while reset is asserted so nothing is issued into reset.
        if (!rst) begin
            if (bus.d_req_i && !(bus.if_req_i && w_at_limit)) begin
                w_gnt_d = 1'b1;
            end else if (bus.if_req_i) begin
                w_gnt_if = 1'b1;
            end
        end

        if (w_gnt_d) begin
            w_mem_req   = 1'b1;
            w_mem_we    = bus.d_we_i;
            w_mem_addr  = bus.d_addr_i;
            w_mem_wdata = bus.d_wdata_i;
            w_mem_ctrl  = bus.d_ctrl_i;
            if (!bus.d_we_i) begin
                w_owner_nxt = OWN_D;
            end
        end else if (w_gnt_if) begin
            w_mem_req   = 1'b1;
            w_mem_addr  = bus.if_addr_i;
            w_mem_ctrl  = ACC_WORD;
            w_owner_nxt = OWN_IF;
        end

        case (r_owner)
            OWN_IF: begin
                w_if_rvalid = 1'b1;
                w_if_rdata  = bus.mem_rdata_i;
            end
            OWN_D: begin
                w_d_rvalid = 1'b1;
                w_d_rdata  = bus.mem_rdata_i;
            end
            default: ;
        endcase
    end

    assign bus.if_gnt_o    = w_gnt_if;
    assign bus.if_rvalid_o = w_if_rvalid;
    assign bus.if_rdata_o  = w_if_rdata;
    assign bus.d_gnt_o     = w_gnt_d;
    assign bus.d_rvalid_o  = w_d_rvalid;
    assign bus.d_rdata_o   = w_d_rdata;
    assign bus.mem_req_o   = w_mem_req;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = w_mem_wdata;
    assign bus.mem_ctrl_o  = w_mem_ctrl;
    assign bus.busy_o      = (r_owner != OWN_NONE);
endmodule
